// File: rtl/pipe_interlock_ctrl_pkg.sv
// Shared definitions for the pipeline interlock controller.
//   fwd_sel_e      : EX operand source select encoding (reg file / WB / EX-MEM)
//   stage_flags_t  : per-stage metadata flags carried alongside the dst/src indices
//   mc_state_e     : multi-cycle counter state
package pipe_interlock_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // Stage metadata layout; register indices live in parallel AW-wide registers
  // in the top level because the package is width-agnostic.
  typedef struct packed {
    logic vld;
    logic wr;
    logic ld;
    logic mc;
  } stage_flags_t;

  localparam stage_flags_t STAGE_EMPTY = '0;

  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_RUN  = 1'b1
  } mc_state_e;

endpackage

// File: rtl/pipe_interlock_ctrl_mc_counter.sv
// Multi-cycle op latency counter.
//   clk, reset : clock, synchronous active-high reset
//   start_i    : load the counter with MC_LAT-1 (only honoured while idle)
//   idle_o     : no op in progress
//   done_o     : final cycle of the op (counter reached zero)
module pipe_interlock_ctrl_mc_counter
  import pipe_interlock_ctrl_pkg::*;
#(
  parameter int unsigned MC_LAT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  output logic idle_o,
  output logic done_o
);

  localparam int unsigned CW = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(MC_LAT - 1);

  mc_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MC_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == MC_IDLE) begin
      if (start_i) begin
        state_d = MC_RUN;
        cnt_d   = LOAD_VAL;
      end
    end else begin
      if (cnt_q == '0) begin
        state_d = MC_IDLE;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_comb begin
    idle_o = (state_q == MC_IDLE);
    done_o = (state_q == MC_RUN) && (cnt_q == '0);
  end

endmodule

// File: rtl/pipe_interlock_ctrl.sv
// Central stall/flush/forward controller for the 5-stage pipeline.
// Tracks metadata for ID/EX (S2), EX/MEM (S3), MEM/WB (S4) and drives:
//   pc_en, ifid_en, ifid_flush        : front-end enables / wrong-path squash
//   idex_en, idex_bubble              : ID/EX enable / bubble insert
//   exmem_en, exmem_bubble, memwb_en  : back-end enables / bubble insert
//   fwd_a_sel, fwd_b_sel              : EX operand forward selects
//   mc_start, mc_busy                 : multi-cycle unit control/status
// Inputs describe the instruction in IF/ID (id_*); fetch_vld is accepted for
// interface compatibility and does not affect any decision.
module pipe_interlock_ctrl
  import pipe_interlock_ctrl_pkg::*;
#(
  parameter int unsigned AW         = 5,
  parameter int unsigned MC_LAT     = 8,
  parameter int unsigned DELAY_SLOT = 1,
  parameter int unsigned R0_ZERO    = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fetch_vld,
  input  logic          id_vld,
  input  logic [AW-1:0] id_rs,
  input  logic          id_rs_use,
  input  logic [AW-1:0] id_rs2,
  input  logic          id_rs2_use,
  input  logic [AW-1:0] id_dst,
  input  logic          id_wr,
  input  logic          id_ld,
  input  logic          id_br,
  input  logic          id_redirect,
  input  logic          id_mc,
  output logic          pc_en,
  output logic          ifid_en,
  output logic          ifid_flush,
  output logic          idex_en,
  output logic          idex_bubble,
  output logic          exmem_en,
  output logic          exmem_bubble,
  output logic          memwb_en,
  output logic [1:0]    fwd_a_sel,
  output logic [1:0]    fwd_b_sel,
  output logic          mc_start,
  output logic          mc_busy
);

  stage_flags_t  s2_q, s2_d, s3_q, s3_d, s4_q, s4_d;
  logic [AW-1:0] s2_dst_q, s2_dst_d, s2_rs_q, s2_rs_d, s2_rs2_q, s2_rs2_d;
  logic [AW-1:0] s3_dst_q, s3_dst_d, s4_dst_q, s4_dst_d;

  logic mc_idle, mc_done, mc_start_w, freeze;
  logic hz_rs_s2, hz_rs2_s2, hz_rs_s3ld, hz_rs2_s3ld;
  logic lduse, brstall, stall, redirect;

  // A stage produces a value for index x if it holds a valid register writer
  // targeting x; index 0 is excluded when it is hardwired to zero.
  function automatic logic match(input stage_flags_t f, input logic [AW-1:0] dst,
                                 input logic [AW-1:0] x);
    return f.vld && f.wr && (dst == x) && !((R0_ZERO != 0) && (x == '0));
  endfunction

  pipe_interlock_ctrl_mc_counter #(
    .MC_LAT(MC_LAT)
  ) u_mc_counter (
    .clk    (clk),
    .reset  (reset),
    .start_i(mc_start_w),
    .idle_o (mc_idle),
    .done_o (mc_done)
  );

  // The freeze covers the start cycle plus every running cycle except the
  // last (done), giving exactly MC_LAT frozen cycles.
  always_comb begin
    mc_start_w = !reset && mc_idle && s2_q.vld && s2_q.mc;
    freeze     = mc_start_w || (!reset && !mc_idle && !mc_done);
    mc_start   = mc_start_w;
    mc_busy    = freeze;
  end

  always_comb begin
    hz_rs_s2    = id_rs_use  && match(s2_q, s2_dst_q, id_rs);
    hz_rs2_s2   = id_rs2_use && match(s2_q, s2_dst_q, id_rs2);
    hz_rs_s3ld  = id_rs_use  && match(s3_q, s3_dst_q, id_rs)  && s3_q.ld;
    hz_rs2_s3ld = id_rs2_use && match(s3_q, s3_dst_q, id_rs2) && s3_q.ld;
    lduse       = id_vld && (hz_rs_s2 || hz_rs2_s2) && s2_q.ld;
    // Branches resolve in ID, so any in-flight writer in EX and a load in MEM
    // cannot yet be forwarded to them.
    brstall     = id_vld && id_br && (hz_rs_s2 || hz_rs2_s2 || hz_rs_s3ld || hz_rs2_s3ld);
    stall       = lduse || brstall;
    redirect    = id_vld && id_redirect;
  end

  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_en      = 1'b1;
    idex_bubble  = 1'b0;
    exmem_en     = 1'b1;
    exmem_bubble = 1'b0;
    memwb_en     = 1'b1;
    if (!reset) begin
      if (freeze) begin
        // Front end holds while older ops drain past EX.
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idex_en      = 1'b0;
        exmem_bubble = 1'b1;
      end else if (stall) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
      end else if (redirect) begin
        ifid_flush = (DELAY_SLOT == 0);
      end
    end
  end

  always_comb begin
    fwd_a_sel = FWD_RF;
    fwd_b_sel = FWD_RF;
    if (!reset && s2_q.vld) begin
      if (match(s3_q, s3_dst_q, s2_rs_q)) begin
        fwd_a_sel = FWD_MEM;
      end else if (match(s4_q, s4_dst_q, s2_rs_q)) begin
        fwd_a_sel = FWD_WB;
      end
      if (match(s3_q, s3_dst_q, s2_rs2_q)) begin
        fwd_b_sel = FWD_MEM;
      end else if (match(s4_q, s4_dst_q, s2_rs2_q)) begin
        fwd_b_sel = FWD_WB;
      end
    end
  end

  always_comb begin
    s2_d     = s2_q;
    s2_dst_d = s2_dst_q;
    s2_rs_d  = s2_rs_q;
    s2_rs2_d = s2_rs2_q;
    s3_d     = s3_q;
    s3_dst_d = s3_dst_q;
    s4_d     = s4_q;
    s4_dst_d = s4_dst_q;
    if (idex_en) begin
      s2_d.vld = id_vld && !idex_bubble;
      s2_d.wr  = id_wr;
      s2_d.ld  = id_ld;
      s2_d.mc  = id_mc;
      s2_dst_d = id_dst;
      s2_rs_d  = id_rs;
      s2_rs2_d = id_rs2;
    end
    if (exmem_en) begin
      s3_d     = s2_q;
      s3_d.vld = s2_q.vld && !exmem_bubble;
      s3_dst_d = s2_dst_q;
    end
    if (memwb_en) begin
      s4_d     = s3_q;
      s4_dst_d = s3_dst_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_q     <= STAGE_EMPTY;
      s3_q     <= STAGE_EMPTY;
      s4_q     <= STAGE_EMPTY;
      s2_dst_q <= '0;
      s2_rs_q  <= '0;
      s2_rs2_q <= '0;
      s3_dst_q <= '0;
      s4_dst_q <= '0;
    end else begin
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      s4_q     <= s4_d;
      s2_dst_q <= s2_dst_d;
      s2_rs_q  <= s2_rs_d;
      s2_rs2_q <= s2_rs2_d;
      s3_dst_q <= s3_dst_d;
      s4_dst_q <= s4_dst_d;
    end
  end

  logic unused_sigs;
  assign unused_sigs = ^{fetch_vld, s3_q.mc, s4_q.ld, s4_q.mc};

endmodule

// File: tb/tb_pipe_interlock_ctrl.sv
module tb_pipe_interlock_ctrl;

  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, fetch_vld, id_vld, id_rs_use, id_rs2_use, id_wr, id_ld, id_br, id_redirect, id_mc;
  logic [AW-1:0] id_rs, id_rs2, id_dst;

  logic       o_pc_en[2], o_ifid_en[2], o_ifid_flush[2], o_idex_en[2], o_idex_bubble[2];
  logic       o_exmem_en[2], o_exmem_bubble[2], o_memwb_en[2], o_mc_start[2], o_mc_busy[2];
  logic [1:0] o_fwd_a[2], o_fwd_b[2];

  pipe_interlock_ctrl #(.AW(AW), .MC_LAT(4), .DELAY_SLOT(0), .R0_ZERO(1)) dut0 (
    .clk(clk), .reset(reset), .fetch_vld(fetch_vld), .id_vld(id_vld),
    .id_rs(id_rs), .id_rs_use(id_rs_use), .id_rs2(id_rs2), .id_rs2_use(id_rs2_use),
    .id_dst(id_dst), .id_wr(id_wr), .id_ld(id_ld), .id_br(id_br),
    .id_redirect(id_redirect), .id_mc(id_mc),
    .pc_en(o_pc_en[0]), .ifid_en(o_ifid_en[0]), .ifid_flush(o_ifid_flush[0]),
    .idex_en(o_idex_en[0]), .idex_bubble(o_idex_bubble[0]), .exmem_en(o_exmem_en[0]),
    .exmem_bubble(o_exmem_bubble[0]), .memwb_en(o_memwb_en[0]),
    .fwd_a_sel(o_fwd_a[0]), .fwd_b_sel(o_fwd_b[0]),
    .mc_start(o_mc_start[0]), .mc_busy(o_mc_busy[0]));

  pipe_interlock_ctrl #(.AW(AW), .MC_LAT(8), .DELAY_SLOT(1), .R0_ZERO(0)) dut1 (
    .clk(clk), .reset(reset), .fetch_vld(fetch_vld), .id_vld(id_vld),
    .id_rs(id_rs), .id_rs_use(id_rs_use), .id_rs2(id_rs2), .id_rs2_use(id_rs2_use),
    .id_dst(id_dst), .id_wr(id_wr), .id_ld(id_ld), .id_br(id_br),
    .id_redirect(id_redirect), .id_mc(id_mc),
    .pc_en(o_pc_en[1]), .ifid_en(o_ifid_en[1]), .ifid_flush(o_ifid_flush[1]),
    .idex_en(o_idex_en[1]), .idex_bubble(o_idex_bubble[1]), .exmem_en(o_exmem_en[1]),
    .exmem_bubble(o_exmem_bubble[1]), .memwb_en(o_memwb_en[1]),
    .fwd_a_sel(o_fwd_a[1]), .fwd_b_sel(o_fwd_b[1]),
    .mc_start(o_mc_start[1]), .mc_busy(o_mc_busy[1]));

  // Reference model configuration per instance.
  int P_LAT[2] = '{4, 8};
  bit P_DS[2]  = '{1'b0, 1'b1};
  bit P_R0[2]  = '{1'b1, 1'b0};

  // Model pipeline: stage index 0=ID/EX, 1=EX/MEM, 2=MEM/WB.
  bit m_vld[2][3], m_wr[2][3], m_ld[2][3], m_mc[2][3];
  int m_dst[2][3], m_rs[2][3], m_rs2[2][3];
  int m_rem[2];     // frozen cycles still owed to the op in EX
  bit m_served[2];  // op in EX already had its full latency

  bit e_pc[2], e_ifid[2], e_flush[2], e_idex[2], e_bub[2], e_exmem[2], e_exbub[2], e_memwb[2];
  bit e_start[2], e_busy[2];
  int e_fa[2], e_fb[2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[dut%0d] observed=%0d expected=%0d", tag, k, obs, exp);
    end
  endtask

  function automatic bit mt(input int k, input int s, input int x);
    return m_vld[k][s] && m_wr[k][s] && (m_dst[k][s] == x) && !(P_R0[k] && x == 0);
  endfunction

  function automatic int fwd_of(input int k, input int x);
    if (mt(k, 1, x)) return 2;
    if (mt(k, 2, x)) return 1;
    return 0;
  endfunction

  task automatic model_eval(input int k);
    bit hz2, hz3ld;
    e_pc[k] = 1; e_ifid[k] = 1; e_flush[k] = 0; e_idex[k] = 1; e_bub[k] = 0;
    e_exmem[k] = 1; e_exbub[k] = 0; e_memwb[k] = 1;
    e_start[k] = 0; e_busy[k] = 0; e_fa[k] = 0; e_fb[k] = 0;
    if (!reset) begin
      e_start[k] = !m_served[k] && m_rem[k] == 0 && m_vld[k][0] && m_mc[k][0];
      e_busy[k]  = e_start[k] || m_rem[k] > 0;
      hz2   = (id_rs_use && mt(k, 0, int'(id_rs))) || (id_rs2_use && mt(k, 0, int'(id_rs2)));
      hz3ld = m_ld[k][1] && ((id_rs_use && mt(k, 1, int'(id_rs))) || (id_rs2_use && mt(k, 1, int'(id_rs2))));
      if (e_busy[k]) begin
        e_pc[k] = 0; e_ifid[k] = 0; e_idex[k] = 0; e_exbub[k] = 1;
      end else if (id_vld && ((hz2 && m_ld[k][0]) || (id_br && (hz2 || hz3ld)))) begin
        e_pc[k] = 0; e_ifid[k] = 0; e_bub[k] = 1;
      end else if (id_vld && id_redirect) begin
        e_flush[k] = !P_DS[k];
      end
      if (m_vld[k][0]) begin
        e_fa[k] = fwd_of(k, m_rs[k][0]);
        e_fb[k] = fwd_of(k, m_rs2[k][0]);
      end
    end
  endtask

  task automatic model_advance(input int k);
    int r;
    if (reset) begin
      for (int s = 0; s < 3; s++) m_vld[k][s] = 0;
      m_rem[k] = 0;
      m_served[k] = 0;
    end else begin
      if (e_busy[k]) begin
        r = e_start[k] ? P_LAT[k] : m_rem[k];
        r--;
        m_rem[k] = r;
        if (r == 0) m_served[k] = 1;
      end
      if (e_memwb[k]) begin
        m_vld[k][2] = m_vld[k][1]; m_wr[k][2] = m_wr[k][1]; m_ld[k][2] = m_ld[k][1];
        m_mc[k][2] = m_mc[k][1]; m_dst[k][2] = m_dst[k][1];
      end
      if (e_exmem[k]) begin
        m_vld[k][1] = m_vld[k][0] && !e_exbub[k]; m_wr[k][1] = m_wr[k][0]; m_ld[k][1] = m_ld[k][0];
        m_mc[k][1] = m_mc[k][0]; m_dst[k][1] = m_dst[k][0];
      end
      if (e_idex[k]) begin
        m_vld[k][0] = id_vld && !e_bub[k]; m_wr[k][0] = id_wr; m_ld[k][0] = id_ld;
        m_mc[k][0] = id_mc; m_dst[k][0] = int'(id_dst);
        m_rs[k][0] = int'(id_rs); m_rs2[k][0] = int'(id_rs2);
        m_served[k] = 0;
      end
    end
  endtask

  task automatic compare(input int k);
    chk("pc_en", k, o_pc_en[k], e_pc[k]);
    chk("ifid_en", k, o_ifid_en[k], e_ifid[k]);
    chk("ifid_flush", k, o_ifid_flush[k], e_flush[k]);
    chk("idex_en", k, o_idex_en[k], e_idex[k]);
    chk("idex_bubble", k, o_idex_bubble[k], e_bub[k]);
    chk("exmem_en", k, o_exmem_en[k], e_exmem[k]);
    chk("exmem_bubble", k, o_exmem_bubble[k], e_exbub[k]);
    chk("memwb_en", k, o_memwb_en[k], e_memwb[k]);
    chk("fwd_a_sel", k, o_fwd_a[k], e_fa[k]);
    chk("fwd_b_sel", k, o_fwd_b[k], e_fb[k]);
    chk("mc_start", k, o_mc_start[k], e_start[k]);
    chk("mc_busy", k, o_mc_busy[k], e_busy[k]);
  endtask

  task automatic sample();
    model_eval(0); model_eval(1);
    @(negedge clk);
    compare(0); compare(1);
  endtask

  task automatic advance();
    model_advance(0); model_advance(1);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  task automatic set_id(input bit v, input int rs, input bit ru, input int rs2, input bit r2u,
                        input int dst, input bit wr, input bit ld, input bit br, input bit rd,
                        input bit mc);
    id_vld = v; id_rs = rs[AW-1:0]; id_rs_use = ru; id_rs2 = rs2[AW-1:0]; id_rs2_use = r2u;
    id_dst = dst[AW-1:0]; id_wr = wr; id_ld = ld; id_br = br; id_redirect = rd; id_mc = mc;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  int frz[2], starts[2];

  initial begin
    fetch_vld = 1'b1;
    reset = 1'b1;
    idle();
    @(posedge clk);
    #1;

    // Reset held 3 cycles.
    repeat (3) begin
      sample();
      for (int k = 0; k < 2; k++) chk("rst_pc_en", k, o_pc_en[k], 1);
      advance();
    end
    reset = 1'b0;
    sample();
    for (int k = 0; k < 2; k++) begin
      chk("t1_idex_en", k, o_idex_en[k], 1);
      chk("t1_fwd_a", k, o_fwd_a[k], 0);
    end
    advance();

    // Load-use: lw r3 ; add r4,r3,r5
    set_id(1, 1, 1, 0, 0, 3, 1, 1, 0, 0, 0); cyc();
    set_id(1, 3, 1, 5, 1, 4, 1, 0, 0, 0, 0);
    sample();
    for (int k = 0; k < 2; k++) begin
      chk("t2_stall_pc_en", k, o_pc_en[k], 0);
      chk("t2_stall_bubble", k, o_idex_bubble[k], 1);
    end
    advance();
    sample();
    for (int k = 0; k < 2; k++) chk("t2_resume_pc_en", k, o_pc_en[k], 1);
    advance();
    idle();
    sample();
    for (int k = 0; k < 2; k++) chk("t2_fwd_wb", k, o_fwd_a[k], 1);
    advance();

    // ALU forward: add r3 ; sub r6,r3,r3, then the same through r0
    set_id(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0); cyc();
    set_id(1, 3, 1, 3, 1, 6, 1, 0, 0, 0, 0);
    sample();
    for (int k = 0; k < 2; k++) chk("t3_no_stall", k, o_pc_en[k], 1);
    advance();
    idle();
    sample();
    for (int k = 0; k < 2; k++) begin
      chk("t3_fwd_a_mem", k, o_fwd_a[k], 2);
      chk("t3_fwd_b_mem", k, o_fwd_b[k], 2);
    end
    advance();
    set_id(1, 1, 1, 2, 1, 0, 1, 0, 0, 0, 0); cyc();
    set_id(1, 0, 1, 0, 1, 6, 1, 0, 0, 0, 0); cyc();
    idle();
    sample();
    chk("t3_r0_fwd_a", 0, o_fwd_a[0], 0);
    chk("t3_r0_fwd_b", 0, o_fwd_b[0], 0);
    chk("t3_r0_fwd_a", 1, o_fwd_a[1], 2);
    advance();

    // Branch: add r2 ; beqz r2 (taken)
    set_id(1, 1, 1, 0, 0, 2, 1, 0, 0, 0, 0); cyc();
    set_id(1, 2, 1, 0, 0, 0, 0, 0, 1, 1, 0);
    sample();
    for (int k = 0; k < 2; k++) begin
      chk("t5_br_stall", k, o_pc_en[k], 0);
      chk("t5_br_bubble", k, o_idex_bubble[k], 1);
      chk("t5_no_flush_stalled", k, o_ifid_flush[k], 0);
    end
    advance();
    sample();
    chk("t5_flush_ds0", 0, o_ifid_flush[0], 1);
    chk("t5_flush_ds1", 1, o_ifid_flush[1], 0);
    for (int k = 0; k < 2; k++) chk("t5_redirect_pc_en", k, o_pc_en[k], 1);
    advance();
    idle(); cyc(); cyc();

    // Multi-cycle op behind two adds.
    set_id(1, 1, 1, 2, 1, 7, 1, 0, 0, 0, 0); cyc();
    set_id(1, 1, 1, 2, 1, 8, 1, 0, 0, 0, 0); cyc();
    set_id(1, 10, 1, 11, 1, 0, 0, 0, 0, 0, 1); cyc();
    idle();
    frz = '{0, 0}; starts = '{0, 0};
    for (int i = 0; i < 10; i++) begin
      sample();
      for (int k = 0; k < 2; k++) begin
        if (!o_pc_en[k]) frz[k]++;
        if (o_mc_start[k]) starts[k]++;
        if (i == 0) chk("t4_start", k, o_mc_start[k], 1);
        if (i == 1) begin
          chk("t4_exmem_bubble", k, o_exmem_bubble[k], 1);
          chk("t4_memwb_en", k, o_memwb_en[k], 1);
        end
      end
      advance();
    end
    chk("t4_freeze_len", 0, frz[0], 4);
    chk("t4_freeze_len", 1, frz[1], 8);
    for (int k = 0; k < 2; k++) chk("t4_start_count", k, starts[k], 1);

    // Reset two cycles into a multi-cycle op.
    set_id(1, 10, 1, 11, 1, 0, 0, 0, 0, 0, 1); cyc();
    idle();
    sample();
    for (int k = 0; k < 2; k++) chk("t6_start", k, o_mc_start[k], 1);
    advance();
    cyc();
    reset = 1'b1;
    sample();
    for (int k = 0; k < 2; k++) chk("t6_rst_pc_en", k, o_pc_en[k], 1);
    advance();
    reset = 1'b0;
    sample();
    for (int k = 0; k < 2; k++) begin
      chk("t6_busy_cleared", k, o_mc_busy[k], 0);
      chk("t6_no_restart", k, o_mc_start[k], 0);
      chk("t6_pc_en", k, o_pc_en[k], 1);
    end
    advance();

    // Back-to-back multi-cycle ops held in ID.
    set_id(1, 10, 1, 11, 1, 0, 0, 0, 0, 0, 1);
    starts = '{0, 0};
    for (int i = 0; i < 11; i++) begin
      sample();
      for (int k = 0; k < 2; k++) if (o_mc_start[k]) starts[k]++;
      advance();
    end
    for (int k = 0; k < 2; k++) chk("b2b_start_count", k, starts[k], 2);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      set_id($urandom_range(0, 7) != 0,
             $urandom_range(0, 3), $urandom_range(0, 1) == 1,
             $urandom_range(0, 3), $urandom_range(0, 1) == 1,
             $urandom_range(0, 3), $urandom_range(0, 3) != 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
